// File: rtl/relay_actuator_fb.sv
// Relay coil driver with aux-contact confirmation, dwell enforcement and fault latch.
// Optional RELAY_OP_COUNTER_EN adds op_count, the completed open-operation count.
module relay_actuator_fb #(
    parameter int unsigned CNT_W            = 8,
    parameter int unsigned DEBOUNCE_TICKS   = 4,
    parameter int unsigned FB_TIMEOUT_TICKS = 13,
    parameter int unsigned MIN_DWELL_TICKS  = 63
) (
    input  logic        clk_16ms,
    input  logic        rst,
    input  logic        enable,
    input  logic        relay_cmd,
    input  logic        fb_raw,
    input  logic        fault_clr,
    output logic        coil_out,
    output logic        relay_state,
    output logic        busy,
    output logic        fb_fault
`ifdef RELAY_OP_COUNTER_EN
    ,
    output logic [15:0] op_count
`endif
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FB_TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL    = CNT_W'(MIN_DWELL_TICKS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic               sync1_q, sync2_q;
    logic               fb_db_q, fb_db_d;
    logic               coil_q, coil_d;
    logic               rstate_q, rstate_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic               dwell_sat;
    logic               timeout;
    logic               entering;

    assign dwell_sat = (dwell_q == DWELL);
    assign timeout   = (timer_q == TMO_LAST);

    always_comb begin
        db_cnt_d = '0;
        fb_db_d  = fb_db_q;
        if (sync2_q != fb_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                fb_db_d = ~fb_db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOSED: begin
                // Contact movement without a command outranks a pending open.
                if (fb_db_q) begin
                    state_d = ST_FAULT;
                end else if (relay_cmd && dwell_sat) begin
                    state_d = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (fb_db_q) begin
                    state_d = ST_OPEN;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (!fb_db_q) begin
                    state_d = ST_FAULT;
                end else if (!relay_cmd && dwell_sat) begin
                    state_d = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (!fb_db_q) begin
                    state_d = ST_CLOSED;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr && fb_db_q) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);
        dwell_d  = dwell_q;
        timer_d  = timer_q;
        if (state_d == ST_OPEN || state_d == ST_CLOSED) begin
            if (entering) begin
                dwell_d = '0;
            end else if (!dwell_sat) begin
                dwell_d = dwell_q + 1'b1;
            end
        end
        if (state_d == ST_OPENING || state_d == ST_CLOSING) begin
            timer_d = entering ? '0 : timer_q + 1'b1;
        end
    end

    always_comb begin
        coil_d   = (state_d == ST_OPENING) || (state_d == ST_OPEN) ||
                   (state_d == ST_FAULT);
        busy_d   = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
        fault_d  = (state_d == ST_FAULT);
        rstate_d = 1'b0;
        if (state_d == ST_OPEN) begin
            rstate_d = 1'b1;
        end else if (state_d == ST_FAULT) begin
            rstate_d = fb_db_q;
        end
    end

    always_ff @(posedge clk_16ms) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            fb_db_q  <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= ST_CLOSED;
            timer_q  <= '0;
            dwell_q  <= DWELL;
            coil_q   <= 1'b0;
            rstate_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync1_q  <= fb_raw;
            sync2_q  <= sync1_q;
            fb_db_q  <= fb_db_d;
            db_cnt_q <= db_cnt_d;
            if (enable) begin
                state_q  <= state_d;
                timer_q  <= timer_d;
                dwell_q  <= dwell_d;
                coil_q   <= coil_d;
                rstate_q <= rstate_d;
                busy_q   <= busy_d;
                fault_q  <= fault_d;
            end
        end
    end

    assign coil_out    = coil_q;
    assign relay_state = rstate_q;
    assign busy        = busy_q;
    assign fb_fault    = fault_q;

`ifdef RELAY_OP_COUNTER_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk_16ms) begin
        if (!rst) begin
            op_cnt_q <= '0;
        end else if (enable && state_q == ST_OPENING &&
                     state_d == ST_OPEN && op_cnt_q != 16'hFFFF) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule

// File: doc/relay_actuator_fb.md
Name: relay_actuator_fb

Overview:
- Drives the protection relay coil from the open command issued by the per-channel protection FSM.
- Confirms every open and close via the relay auxiliary contact feedback, and enforces a minimum dwell between operations.
- Drives the coil to the fail-safe open position and latches a fault on feedback timeout or unexpected contact movement.
- Sits between the protection FSM's relay command and the physical relay/aux-contact pins.
- Runs on the 16 ms system tick.

Parameters:
- CNT_W, 8, width of the timeout and dwell counters; every tick parameter below must be < 2^CNT_W.
- DEBOUNCE_TICKS, 4, consecutive ticks fb must disagree with its debounced value before the debounced value changes (64 ms).
- FB_TIMEOUT_TICKS, 13, maximum ticks in OPENING/CLOSING before a fault (~208 ms).
- MIN_DWELL_TICKS, 63, minimum ticks in OPEN or CLOSED before the next operation (~1 s).

Ports:
- clk_16ms  in  1  system tick clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  1 = FSM advances; 0 = state, timers and outputs frozen.
- relay_cmd  in  1  1 = request relay open, 0 = request closed.
- fb_raw  in  1  asynchronous aux contact; 1 = contacts open.
- fault_clr  in  1  single-tick fault acknowledge.
- coil_out  out  1  coil drive; 1 = open relay.
- relay_state  out  1  confirmed contact position; 1 = open.
- busy  out  1  operation in progress.
- fb_fault  out  1  latched feedback fault.

Behaviour:
- Reset (rst=0 at an edge):
  - state=CLOSED; coil_out=0, relay_state=0, busy=0, fb_fault=0.
  - Sync flops and fb_db = 0; timer = 0.
  - Dwell counter preset to MIN_DWELL_TICKS, so the first open is not delayed.
  - Reset mid-operation aborts immediately to this state.
- Feedback path (runs regardless of enable):
  - 2-flop synchronizer, then debounce.
  - fb_db toggles on the tick its mismatch counter reaches DEBOUNCE_TICKS; any agreement clears the counter.
  - Latency from an fb_raw edge to fb_db = DEBOUNCE_TICKS+2 ticks; to relay_state = DEBOUNCE_TICKS+3 ticks.
- Counters:
  - Dwell counter increments in CLOSED/OPEN, saturates at MIN_DWELL_TICKS, clears on entry to OPEN/CLOSED.
  - Timer clears on entry to OPENING/CLOSING and increments each enabled tick there.
- All outputs are registered. relay_cmd sampled at tick N moves coil_out at tick N+1.
- CLOSED: coil_out=0, relay_state=0.
  - relay_cmd=1 and dwell saturated -> OPENING.
  - fb_db=1 -> FAULT (unexpected movement).
  - If both hold in the same tick, FAULT wins.
- OPENING: coil_out=1, busy=1.
  - fb_db=1 -> OPEN.
  - Else timer==FB_TIMEOUT_TICKS-1 -> FAULT.
  - relay_cmd ignored: the operation always completes.
- OPEN: coil_out=1, relay_state=1, busy=0.
  - relay_cmd=0 and dwell saturated -> CLOSING.
  - fb_db=0 -> FAULT (takes priority).
- CLOSING: coil_out=0, busy=1.
  - fb_db=0 -> CLOSED.
  - Else timeout (same rule as OPENING) -> FAULT.
  - relay_cmd ignored.
- FAULT: coil_out=1 (fail-safe), fb_fault=1, busy=0, relay_state=fb_db.
  - fault_clr=1 with fb_db=1 -> OPEN: fb_fault=0, dwell cleared.
  - fault_clr with fb_db=0 is ignored; stay in FAULT.
- enable=0: state, timer, dwell and all outputs hold. A mismatch is evaluated on the first enabled tick.
- Encoding: 3-bit state; any illegal encoding -> FAULT.

Optional Feature:
- Macro: RELAY_OP_COUNTER_EN.
- Defined:
  - Adds output op_count[15:0] = number of completed OPENING->OPEN transitions.
  - Saturates at 16'hFFFF; cleared by reset only.
  - FAULT->OPEN does not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=0 for 2 ticks with fb_raw=0 -> coil_out=0, relay_state=0, busy=0, fb_fault=0.
- Normal open: relay_cmd=1 at tick 0, fb_raw=1 from tick 3 -> coil_out=1 and busy=1 at tick 1; relay_state=1 and busy=0 at tick 10; op_count=1 (if enabled).
- Open timeout: relay_cmd=1, fb_raw held 0 -> fb_fault=1 at tick 14, coil_out stays 1. fault_clr with fb_raw=0 -> still FAULT. Then fb_raw=1 for 7 ticks plus fault_clr -> OPEN, fb_fault=0.
- Dwell: enter OPEN at tick T, relay_cmd=0 at T -> coil_out stays 1 until tick T+64. It falls at T+64, and CLOSED follows 7 ticks after fb_raw falls.
- Debounce: in CLOSED, fb_raw=1 pulse of 3 ticks -> no fault. Pulse of 4 ticks -> fb_fault=1 and coil_out=1 at fall+7... specifically 7 ticks after the pulse's rising edge.
- Freeze and reset: enable=0 during OPENING for 20 ticks -> no timeout, outputs held. rst=0 mid-OPENING -> coil_out=0, CLOSED next tick.
